mips_lsu: RTL and testbench
===========================

Name: mips_lsu

Overview:
Load/store unit on the consumer side of the MIPS decoder's memory-control outputs.
- Accepts store enables (ctrl_sw/sh/sb_memwren), load flags (ctrl_lw/lh/lb_load) and ctrl_load_se, plus the ALU effective address and the rt data.
- Runs one request/acknowledge transaction per instruction on a word-addressed, byte-enabled data-memory port.
- Returns aligned, extended load data for the register-file write-back mux.
- Stalls the single-cycle core while the access is outstanding.

Parameters:
TIMEOUT_CYCLES, 64, cycles in REQ without mem_ack before abort; used only with MIPS_LSU_TIMEOUT_EN.

Ports:
clk  in  1  core clock
rst_b  in  1  synchronous active-low reset
lsu_valid  in  1  instruction present in the memory stage
ctrl_sw_memwren / ctrl_sh_memwren / ctrl_sb_memwren  in  1 each  store word / half / byte
ctrl_lw_load / ctrl_lh_load / ctrl_lb_load  in  1 each  load word / half / byte
ctrl_load_se  in  1  sign-extend sub-word load (1) or zero-extend (0)
lsu_addr  in  32  byte effective address
lsu_store_data  in  32  rt value
lsu_stall  out  1  hold PC and pipeline
lsu_done  out  1  one-cycle completion pulse
lsu_load_data  out  32  formatted load result, valid while lsu_done=1
lsu_align_exc  out  1  misaligned access, valid with lsu_done
lsu_bus_err  out  1  memory timeout, valid with lsu_done
mem_req  out  1  memory request
mem_we  out  1  1 = write
mem_addr  out  30  word address, lsu_addr[31:2]
mem_be  out  4  byte enables, bit n = bits 8n+7:8n
mem_wdata  out  32  write data
mem_ack  in  1  request accepted and completed this cycle
mem_rdata  in  32  read data, valid with mem_ack

Behaviour:
- Memory op present: lsu_valid & (any store or load flag).
- Multi-hot flags resolve by priority SW > SH > SB > LW > LH > LB.
- Byte ordering is little-endian: lane n corresponds to addr[1:0] = n.
- States: IDLE, REQ, RESP.
- IDLE, memory op present and aligned:
  - Register mem_addr, mem_we, mem_be, mem_wdata and the load kind/offset/se.
  - Go to REQ with mem_req = 1.
- IDLE, memory op present and misaligned (word with addr[1:0] != 0, half with addr[0] = 1):
  - Go to RESP with lsu_align_exc = 1; no mem_req.
- REQ:
  - mem_req and all mem_* outputs stay stable until mem_ack is sampled 1.
  - On mem_ack: register the formatted load data, drop mem_req, go to RESP.
- RESP: lsu_done = 1 for exactly one cycle, then IDLE. lsu_align_exc and lsu_bus_err are cleared on leaving RESP.
- Latency: minimum 3 cycles from acceptance (accept, REQ with ack, RESP). A new op may be accepted in the IDLE cycle following RESP.
- lsu_stall is combinational: (memory op present) & ~lsu_done. It is 0 for non-memory instructions.
- Store formatting:
  - SW: be = 1111, wdata = data.
  - SH: wdata = {data[15:0], data[15:0]}; be = 1100 if addr[1] else 0011.
  - SB: wdata = data[7:0] replicated to all 4 lanes; be = 1 << addr[1:0].
- Load formatting:
  - LW: rdata unchanged; ctrl_load_se ignored.
  - LH: select half by addr[1], then sign- or zero-extend.
  - LB: select byte by addr[1:0], then sign- or zero-extend.
  - Stores return lsu_load_data = 0.
- Signals ignored:
  - mem_ack outside REQ.
  - lsu_valid deasserting mid-transaction: the transaction completes and lsu_done still pulses.
  - Input changes after acceptance.
- Reset: rst_b = 0 at an edge forces IDLE, even mid-REQ, and clears every registered output to 0 (mem_req, mem_we, mem_addr, mem_be, mem_wdata, lsu_done, lsu_load_data, lsu_align_exc, lsu_bus_err, timeout counter).

Optional Feature:
MIPS_LSU_TIMEOUT_EN
- Defined:
  - An 8-bit counter clears on entry to REQ and increments each REQ cycle without mem_ack.
  - When the count reaches TIMEOUT_CYCLES-1 without ack: drop mem_req, go to RESP with lsu_bus_err = 1 and lsu_load_data = 0.
  - A mem_ack arriving in the same cycle wins and no error is raised.
- Undefined: REQ waits indefinitely; lsu_bus_err is tied to 0.

Test Plan:
1. SW, addr 0x100, data 0xDEADBEEF, ack on the 3rd REQ cycle -> mem_addr 0x40, mem_we 1, be 1111, wdata 0xDEADBEEF held 3 cycles; lsu_done the cycle after ack; lsu_stall 1 until then.
2. LB, addr 0x103, rdata 0x80123456, se 1 -> lsu_load_data 0xFFFFFF80; repeat with se 0 -> 0x00000080; with LBU at 0x101 -> 0x00000034.
3. SH, addr 0x102, data 0x0000ABCD -> be 1100, wdata 0xABCDABCD; LH at 0x102, rdata 0x8001FFFF, se 1 -> 0xFFFF8001.
4. LW at 0x102 -> no mem_req; lsu_done and lsu_align_exc in cycle 2; load_data 0; a following aligned LW is accepted the next IDLE cycle.
5. rst_b low for one edge during REQ -> mem_req 0 next cycle, no lsu_done, all outputs 0; a later ack is ignored.
6. (MIPS_LSU_TIMEOUT_EN, TIMEOUT_CYCLES 4) LW with no ack -> mem_req for 4 cycles, then lsu_done with lsu_bus_err 1; ack in the 4th cycle -> normal completion, no error.

Source files
------------

// File: rtl/mips_lsu.sv
// mips_lsu -- load/store unit for the single-cycle MIPS core.
//
// Takes the decoder's store enables / load flags together with the ALU
// effective address and rt data, and runs one request/acknowledge
// transaction per memory instruction on a word-addressed, byte-enabled data
// memory port. Stores are lane-replicated with matching byte enables. Load
// results are lane-selected and sign/zero-extended for the write-back mux.
// The core is stalled while an access is outstanding.
//
// Optional build macro: MIPS_LSU_TIMEOUT_EN
//   When defined, a request with no mem_ack for TIMEOUT_CYCLES cycles is
//   abandoned and completes with lsu_bus_err = 1. When undefined, a request
//   waits for mem_ack indefinitely and lsu_bus_err stays 0.
//
// Ports:
//   clk, rst_b               core clock, synchronous active-low reset
//   lsu_valid                instruction present in the memory stage
//   ctrl_s{w,h,b}_memwren    store word / half / byte
//   ctrl_l{w,h,b}_load       load word / half / byte
//   ctrl_load_se             sign-extend (1) / zero-extend (0) sub-word loads
//   lsu_addr, lsu_store_data byte effective address, rt value
//   lsu_stall                hold PC and pipeline (combinational)
//   lsu_done                 one-cycle completion pulse
//   lsu_load_data            formatted load result, valid with lsu_done
//   lsu_align_exc            misaligned access, valid with lsu_done
//   lsu_bus_err              memory timeout, valid with lsu_done
//   mem_req/we/addr/be/wdata data memory request side
//   mem_ack, mem_rdata       data memory completion and read data
module mips_lsu #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst_b,
   input  logic        lsu_valid,
   input  logic        ctrl_sw_memwren,
   input  logic        ctrl_sh_memwren,
   input  logic        ctrl_sb_memwren,
   input  logic        ctrl_lw_load,
   input  logic        ctrl_lh_load,
   input  logic        ctrl_lb_load,
   input  logic        ctrl_load_se,
   input  logic [31:0] lsu_addr,
   input  logic [31:0] lsu_store_data,
   output logic        lsu_stall,
   output logic        lsu_done,
   output logic [31:0] lsu_load_data,
   output logic        lsu_align_exc,
   output logic        lsu_bus_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [29:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   // Access size; also used as the registered load kind (NONE for stores).
   localparam logic [1:0] SZ_NONE = 2'd0;
   localparam logic [1:0] SZ_WORD = 2'd1;
   localparam logic [1:0] SZ_HALF = 2'd2;
   localparam logic [1:0] SZ_BYTE = 2'd3;

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [1:0]  state;
   logic [1:0]  ld_kind;
   logic [1:0]  ld_off;
   logic        ld_se;
   logic [7:0]  tmo_cnt;

   logic        op_present;
   logic        is_store;
   logic [1:0]  size;
   logic        misaligned;
   logic [3:0]  be_next;
   logic [31:0] wdata_next;

   // Lane-select and extend a read word. Stores (kind NONE) return 0.
   function automatic logic [31:0] fmt_load(input logic [1:0]  kind,
                                            input logic [1:0]  off,
                                            input logic        se,
                                            input logic [31:0] rdata);
      logic [15:0] h;
      logic [7:0]  b;
      h = off[1] ? rdata[31:16] : rdata[15:0];
      case (off)
         2'd0:    b = rdata[7:0];
         2'd1:    b = rdata[15:8];
         2'd2:    b = rdata[23:16];
         default: b = rdata[31:24];
      endcase
      case (kind)
         SZ_WORD: return rdata;
         SZ_HALF: return {{16{se & h[15]}}, h};
         SZ_BYTE: return {{24{se & b[7]}}, b};
         default: return 32'd0;
      endcase
   endfunction

   // Flag decode, priority SW > SH > SB > LW > LH > LB.
   always_comb begin
      is_store = 1'b0;
      size     = SZ_NONE;
      if (ctrl_sw_memwren) begin
         is_store = 1'b1;
         size     = SZ_WORD;
      end else if (ctrl_sh_memwren) begin
         is_store = 1'b1;
         size     = SZ_HALF;
      end else if (ctrl_sb_memwren) begin
         is_store = 1'b1;
         size     = SZ_BYTE;
      end else if (ctrl_lw_load) begin
         size     = SZ_WORD;
      end else if (ctrl_lh_load) begin
         size     = SZ_HALF;
      end else if (ctrl_lb_load) begin
         size     = SZ_BYTE;
      end
   end

   assign op_present = lsu_valid & (size != SZ_NONE);
   assign lsu_stall  = op_present & ~lsu_done;

   assign misaligned = ((size == SZ_WORD) && (lsu_addr[1:0] != 2'd0)) ||
                       ((size == SZ_HALF) && lsu_addr[0]);

   // Byte enables apply to loads too so the memory sees the accessed lanes.
   always_comb begin
      be_next    = 4'b0000;
      wdata_next = 32'd0;
      case (size)
         SZ_WORD: begin
            be_next    = 4'b1111;
            wdata_next = lsu_store_data;
         end
         SZ_HALF: begin
            be_next    = lsu_addr[1] ? 4'b1100 : 4'b0011;
            wdata_next = {2{lsu_store_data[15:0]}};
         end
         SZ_BYTE: begin
            be_next    = 4'b0001 << lsu_addr[1:0];
            wdata_next = {4{lsu_store_data[7:0]}};
         end
         default: ;
      endcase
      if (!is_store)
         wdata_next = 32'd0;
   end

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         state         <= IDLE;
         mem_req       <= 1'b0;
         mem_we        <= 1'b0;
         mem_addr      <= 30'd0;
         mem_be        <= 4'd0;
         mem_wdata     <= 32'd0;
         lsu_done      <= 1'b0;
         lsu_load_data <= 32'd0;
         lsu_align_exc <= 1'b0;
         lsu_bus_err   <= 1'b0;
         ld_kind       <= SZ_NONE;
         ld_off        <= 2'd0;
         ld_se         <= 1'b0;
         tmo_cnt       <= 8'd0;
      end else begin
         case (state)
            // Accept: capture everything, since inputs may change afterwards.
            IDLE: begin
               if (op_present) begin
                  mem_addr  <= lsu_addr[31:2];
                  mem_we    <= is_store;
                  mem_be    <= be_next;
                  mem_wdata <= wdata_next;
                  ld_kind   <= is_store ? SZ_NONE : size;
                  ld_off    <= lsu_addr[1:0];
                  ld_se     <= ctrl_load_se;
                  tmo_cnt   <= 8'd0;
                  if (misaligned) begin
                     state         <= RESP;
                     lsu_done      <= 1'b1;
                     lsu_align_exc <= 1'b1;
                     lsu_load_data <= 32'd0;
                  end else begin
                     state   <= REQ;
                     mem_req <= 1'b1;
                  end
               end
            end
            // Request outstanding: mem_* held until ack (ack wins over timeout).
            REQ: begin
               if (mem_ack) begin
                  lsu_load_data <= fmt_load(ld_kind, ld_off, ld_se, mem_rdata);
                  mem_req       <= 1'b0;
                  lsu_done      <= 1'b1;
                  state         <= RESP;
               end
`ifdef MIPS_LSU_TIMEOUT_EN
               else if (tmo_cnt == TIMEOUT_LAST) begin
                  mem_req       <= 1'b0;
                  lsu_done      <= 1'b1;
                  lsu_bus_err   <= 1'b1;
                  lsu_load_data <= 32'd0;
                  state         <= RESP;
               end
`endif
               else if (tmo_cnt != TIMEOUT_LAST) begin
                  // Saturates so a timeout-free build never wraps.
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end
            // Completion cycle: lsu_done high exactly once.
            RESP: begin
               lsu_done      <= 1'b0;
               lsu_align_exc <= 1'b0;
               lsu_bus_err   <= 1'b0;
               lsu_load_data <= 32'd0;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_lsu.sv
// tb_mips_lsu -- directed bench for mips_lsu.
// Linear sequence of directed steps with hand-computed expected values;
// each comparison is an immediate assertion. The timeout scenario is built
// only with MIPS_LSU_TIMEOUT_EN (TIMEOUT_CYCLES = 4); the default build
// instead checks that a request waits past 64 cycles without a bus error.
module tb_mips_lsu;

`ifdef MIPS_LSU_TIMEOUT_EN
   localparam int TMO = 4;
`else
   localparam int TMO = 64;
`endif

   logic        clk = 1'b0;
   logic        rst_b;
   logic        lsu_valid;
   logic        ctrl_sw_memwren, ctrl_sh_memwren, ctrl_sb_memwren;
   logic        ctrl_lw_load, ctrl_lh_load, ctrl_lb_load;
   logic        ctrl_load_se;
   logic [31:0] lsu_addr;
   logic [31:0] lsu_store_data;
   logic        lsu_stall, lsu_done, lsu_align_exc, lsu_bus_err;
   logic [31:0] lsu_load_data;
   logic        mem_req, mem_we, mem_ack;
   logic [29:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata, mem_rdata;

   int checks = 0;
   int errors = 0;

   mips_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst_b(rst_b), .lsu_valid(lsu_valid),
      .ctrl_sw_memwren(ctrl_sw_memwren), .ctrl_sh_memwren(ctrl_sh_memwren),
      .ctrl_sb_memwren(ctrl_sb_memwren), .ctrl_lw_load(ctrl_lw_load),
      .ctrl_lh_load(ctrl_lh_load), .ctrl_lb_load(ctrl_lb_load),
      .ctrl_load_se(ctrl_load_se), .lsu_addr(lsu_addr),
      .lsu_store_data(lsu_store_data), .lsu_stall(lsu_stall),
      .lsu_done(lsu_done), .lsu_load_data(lsu_load_data),
      .lsu_align_exc(lsu_align_exc), .lsu_bus_err(lsu_bus_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic clear_in();
      lsu_valid       = 1'b0;
      ctrl_sw_memwren = 1'b0;
      ctrl_sh_memwren = 1'b0;
      ctrl_sb_memwren = 1'b0;
      ctrl_lw_load    = 1'b0;
      ctrl_lh_load    = 1'b0;
      ctrl_lb_load    = 1'b0;
      ctrl_load_se    = 1'b0;
      lsu_addr        = 32'd0;
      lsu_store_data  = 32'd0;
      mem_ack         = 1'b0;
      mem_rdata       = 32'd0;
   endtask

   // fl = {sw, sh, sb, lw, lh, lb}
   task automatic set_op(input logic [5:0] fl, input logic se,
                         input logic [31:0] addr, input logic [31:0] sdata);
      lsu_valid       = 1'b1;
      ctrl_sw_memwren = fl[5];
      ctrl_sh_memwren = fl[4];
      ctrl_sb_memwren = fl[3];
      ctrl_lw_load    = fl[2];
      ctrl_lh_load    = fl[1];
      ctrl_lb_load    = fl[0];
      ctrl_load_se    = se;
      lsu_addr        = addr;
      lsu_store_data  = sdata;
      #1;
   endtask

   // One aligned op acknowledged in its first REQ cycle.
   task automatic run_op(input string tag, input logic [5:0] fl, input logic se,
                         input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [31:0] rdata, input logic exp_we,
                         input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                         input logic [31:0] exp_load);
      set_op(fl, se, addr, sdata);
      tick();
      chk1({tag, "_req"}, mem_req, 1'b1);
      chk1({tag, "_we"}, mem_we, exp_we);
      chk({tag, "_addr"}, {2'b0, mem_addr}, {2'b0, addr[31:2]});
      chk({tag, "_be"}, {28'd0, mem_be}, {28'd0, exp_be});
      if (exp_we)
         chk({tag, "_wdata"}, mem_wdata, exp_wdata);
      mem_ack   = 1'b1;
      mem_rdata = rdata;
      tick();
      chk1({tag, "_done"}, lsu_done, 1'b1);
      chk({tag, "_load"}, lsu_load_data, exp_load);
      chk1({tag, "_req_drop"}, mem_req, 1'b0);
      chk1({tag, "_exc"}, lsu_align_exc, 1'b0);
      clear_in();
      tick();
      chk1({tag, "_done_clr"}, lsu_done, 1'b0);
   endtask

   initial begin
      clear_in();
      rst_b = 1'b0;
      tick();
      tick();
      chk1("rst_req", mem_req, 1'b0);
      chk1("rst_we", mem_we, 1'b0);
      chk("rst_addr", {2'b0, mem_addr}, 32'd0);
      chk("rst_be", {28'd0, mem_be}, 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      chk1("rst_done", lsu_done, 1'b0);
      chk("rst_load", lsu_load_data, 32'd0);
      chk1("rst_exc", lsu_align_exc, 1'b0);
      chk1("rst_berr", lsu_bus_err, 1'b0);
      chk1("rst_stall", lsu_stall, 1'b0);
      rst_b = 1'b1;

      // Non-memory instruction and flags without valid: no stall, no request.
      set_op(6'b000000, 1'b0, 32'h100, 32'h0);
      chk1("nonmem_stall", lsu_stall, 1'b0);
      tick();
      chk1("nonmem_req", mem_req, 1'b0);
      clear_in();
      ctrl_lw_load = 1'b1;
      #1;
      chk1("novalid_stall", lsu_stall, 1'b0);
      tick();
      chk1("novalid_req", mem_req, 1'b0);
      clear_in();

      // SW 0x100, ack on the 3rd REQ cycle, outputs held throughout.
      set_op(6'b100000, 1'b0, 32'h100, 32'hDEADBEEF);
      chk1("sw_stall_accept", lsu_stall, 1'b1);
      for (int c = 1; c <= 3; c++) begin
         tick();
         chk1("sw_req", mem_req, 1'b1);
         chk("sw_addr", {2'b0, mem_addr}, 32'h40);
         chk1("sw_we", mem_we, 1'b1);
         chk("sw_be", {28'd0, mem_be}, 32'hF);
         chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
         chk1("sw_stall", lsu_stall, 1'b1);
         chk1("sw_nodone", lsu_done, 1'b0);
         if (c == 3) mem_ack = 1'b1;
      end
      tick();
      chk1("sw_done", lsu_done, 1'b1);
      chk1("sw_stall_done", lsu_stall, 1'b0);
      chk1("sw_req_drop", mem_req, 1'b0);
      chk("sw_load", lsu_load_data, 32'd0);
      clear_in();
      tick();
      chk1("sw_done_pulse", lsu_done, 1'b0);

      // Byte and half loads/stores.
      run_op("lb_se", 6'b000001, 1'b1, 32'h103, 32'h0, 32'h80123456,
             1'b0, 4'b1000, 32'h0, 32'hFFFFFF80);
      run_op("lb_ze", 6'b000001, 1'b0, 32'h103, 32'h0, 32'h80123456,
             1'b0, 4'b1000, 32'h0, 32'h00000080);
      run_op("lbu_101", 6'b000001, 1'b0, 32'h101, 32'h0, 32'h80123456,
             1'b0, 4'b0010, 32'h0, 32'h00000034);
      run_op("sh_102", 6'b010000, 1'b0, 32'h102, 32'h0000ABCD, 32'h0,
             1'b1, 4'b1100, 32'hABCDABCD, 32'h0);
      run_op("lh_102", 6'b000010, 1'b1, 32'h102, 32'h0, 32'h8001FFFF,
             1'b0, 4'b1100, 32'h0, 32'hFFFF8001);
      run_op("sb_102", 6'b001000, 1'b0, 32'h102, 32'h1234565A, 32'h0,
             1'b1, 4'b0100, 32'h5A5A5A5A, 32'h0);
      // Priority: SW beats LW; LH beats LB (byte 2 would give 0xFFFFFFFF).
      run_op("pri_sw_lw", 6'b100100, 1'b0, 32'h104, 32'h01020304, 32'h0,
             1'b1, 4'b1111, 32'h01020304, 32'h0);
      run_op("pri_lh_lb", 6'b000011, 1'b1, 32'h102, 32'h0, 32'h7FFF0000,
             1'b0, 4'b1100, 32'h0, 32'h00007FFF);

      // Misaligned LW: no request, done+exc next cycle, then next op accepted.
      set_op(6'b000100, 1'b0, 32'h102, 32'h0);
      chk1("mis_noreq0", mem_req, 1'b0);
      tick();
      chk1("mis_done", lsu_done, 1'b1);
      chk1("mis_exc", lsu_align_exc, 1'b1);
      chk1("mis_noreq", mem_req, 1'b0);
      chk("mis_load", lsu_load_data, 32'd0);
      set_op(6'b000100, 1'b1, 32'h104, 32'h0);
      tick();
      chk1("mis_exc_clr", lsu_align_exc, 1'b0);
      chk1("mis_done_clr", lsu_done, 1'b0);
      chk1("mis_next_stall", lsu_stall, 1'b1);
      tick();
      chk1("mis_next_req", mem_req, 1'b1);
      chk("mis_next_addr", {2'b0, mem_addr}, 32'h41);
      mem_ack   = 1'b1;
      mem_rdata = 32'h87654321;
      tick();
      chk1("lw_done", lsu_done, 1'b1);
      chk("lw_load", lsu_load_data, 32'h87654321);
      clear_in();
      tick();

      // Reset in the middle of a request.
      set_op(6'b100000, 1'b0, 32'h200, 32'h11223344);
      tick();
      chk1("rreq_req", mem_req, 1'b1);
      clear_in();
      rst_b = 1'b0;
      tick();
      rst_b = 1'b1;
      chk1("rreq_req_clr", mem_req, 1'b0);
      chk1("rreq_we_clr", mem_we, 1'b0);
      chk("rreq_addr_clr", {2'b0, mem_addr}, 32'd0);
      chk("rreq_be_clr", {28'd0, mem_be}, 32'd0);
      chk("rreq_wdata_clr", mem_wdata, 32'd0);
      chk1("rreq_done", lsu_done, 1'b0);
      mem_ack   = 1'b1;
      mem_rdata = 32'hFFFFFFFF;
      tick();
      chk1("rreq_ack_ign_done", lsu_done, 1'b0);
      chk("rreq_ack_ign_load", lsu_load_data, 32'd0);
      mem_ack = 1'b0;
      tick();
      chk1("rreq_ack_ign_done2", lsu_done, 1'b0);
      chk1("rreq_ack_ign_req", mem_req, 1'b0);

`ifdef MIPS_LSU_TIMEOUT_EN
      // No ack: four REQ cycles then bus error.
      set_op(6'b000100, 1'b0, 32'h8, 32'h0);
      for (int c = 1; c <= 4; c++) begin
         tick();
         chk1("tmo_req", mem_req, 1'b1);
         chk1("tmo_nodone", lsu_done, 1'b0);
      end
      tick();
      chk1("tmo_done", lsu_done, 1'b1);
      chk1("tmo_berr", lsu_bus_err, 1'b1);
      chk1("tmo_req_drop", mem_req, 1'b0);
      chk("tmo_load", lsu_load_data, 32'd0);
      clear_in();
      tick();
      chk1("tmo_berr_clr", lsu_bus_err, 1'b0);
      // Ack in the 4th cycle wins over the timeout.
      set_op(6'b000100, 1'b0, 32'h8, 32'h0);
      for (int c = 1; c <= 4; c++) begin
         tick();
         chk1("tmo_ack_req", mem_req, 1'b1);
         if (c == 4) begin
            mem_ack   = 1'b1;
            mem_rdata = 32'hCAFEF00D;
         end
      end
      tick();
      chk1("tmo_ack_done", lsu_done, 1'b1);
      chk1("tmo_ack_berr", lsu_bus_err, 1'b0);
      chk("tmo_ack_load", lsu_load_data, 32'hCAFEF00D);
      clear_in();
      tick();
`else
      // Without the timeout a request waits well past 64 cycles.
      set_op(6'b000100, 1'b0, 32'h8, 32'h0);
      for (int c = 1; c <= 70; c++) tick();
      chk1("wait_req", mem_req, 1'b1);
      chk1("wait_berr", lsu_bus_err, 1'b0);
      chk1("wait_stall", lsu_stall, 1'b1);
      mem_ack   = 1'b1;
      mem_rdata = 32'hCAFEF00D;
      tick();
      chk1("wait_done", lsu_done, 1'b1);
      chk1("wait_berr_done", lsu_bus_err, 1'b0);
      chk("wait_load", lsu_load_data, 32'hCAFEF00D);
      clear_in();
      tick();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
